// File: rtl/spike_pipe_out_fifo_pkg.sv
// Shared constants and state encoding for the spike pipe-out FIFO.
// SPK_MARKER is the frame marker word, used when SPIKE_PIPE_MARKER_EN is defined.
package spike_pipe_out_fifo_pkg;

  localparam logic [15:0] SPK_MARKER      = 16'hFFFF;
  localparam int          DEF_DEPTH_LOG2  = 10;
  localparam int          DEF_BLOCK_WORDS = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLOCK = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/spike_fifo_ram.sv
// Single-clock simple dual-port RAM with a registered read port (block-RAM style).
// The read register only updates when rd_en is high, so the output holds otherwise.
module spike_fifo_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: neither the array nor the read register is reset; a reset would
  // stop the tools from mapping this onto block RAM, and the FIFO pointers
  // already define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spike_pipe_out_fifo.sv
// Spike-ID FIFO feeding an okBTPipeOut endpoint in fixed-size blocks.
// Optional frame markers are compiled in with the macro SPIKE_PIPE_MARKER_EN.
module spike_pipe_out_fifo
  import spike_pipe_out_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spike_valid,
  input  logic [15:0]           spike_id,
  input  logic                  frame_tick,
  input  logic                  ep_read,
  output logic [15:0]           ep_datain,
  output logic                  ep_ready,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic [15:0]           drop_cnt,
  output logic                  underrun
);

  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [DEPTH_LOG2:0]   FILL_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   BLOCK_FILL = BLOCK_WORDS;
  localparam logic [CNT_W-1:0]      BLK_LAST   = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]      BLK_ONE    = 1;

  pipe_state_e             state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [DEPTH_LOG2:0]     count_q, count_nxt;
  logic [CNT_W-1:0]        blk_cnt_q;
  logic [15:0]             drop_q;
  logic                    underrun_q;
  logic                    sel_byp_q;
  logic [15:0]             byp_q;
  logic [15:0]             ram_q;

  logic                    push_req, push, pop, drop, full;
  logic [15:0]             push_data;
  logic                    blk_load, blk_dec, underrun_set, ready_c;
  logic                    load_head, collide;

  // ---------------------------------------------------------------------------
  // Write side: spike IDs, plus an optional pending frame marker.
  // ---------------------------------------------------------------------------
`ifdef SPIKE_PIPE_MARKER_EN
  logic marker_pend_q;
  logic marker_issue;

  assign marker_issue = marker_pend_q && !spike_valid;
  assign push_req     = spike_valid || marker_issue;
  assign push_data    = spike_valid ? spike_id : SPK_MARKER;

  // A tick that lands while a marker is still pending (including the cycle it
  // issues) merges into that one marker.
  always_ff @(posedge clk) begin
    if (!reset_n)          marker_pend_q <= 1'b0;
    else if (marker_issue) marker_pend_q <= 1'b0;
    else if (frame_tick)   marker_pend_q <= 1'b1;
  end
`else
  logic unused_frame_tick;

  assign unused_frame_tick = frame_tick;
  assign push_req          = spike_valid;
  assign push_data         = spike_id;
`endif

  assign full = count_q[DEPTH_LOG2];
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  // ---------------------------------------------------------------------------
  // Block state machine: next state and handshake decode.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    ready_c      = 1'b0;
    pop          = 1'b0;
    blk_load     = 1'b0;
    blk_dec      = 1'b0;
    underrun_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_c = (count_q >= BLOCK_FILL);
        if (ep_read) begin
          if (ready_c) begin
            pop      = 1'b1;
            blk_load = 1'b1;
            // A one-word block completes on this very read.
            if (BLOCK_WORDS > 1) state_d = ST_BLOCK;
          end else begin
            underrun_set = 1'b1;
          end
        end
      end
      ST_BLOCK: begin
        ready_c = 1'b1;
        if (ep_read) begin
          pop     = 1'b1;
          blk_dec = 1'b1;
          if (blk_cnt_q == BLK_ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointer and occupancy arithmetic.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_nxt = count_q + FILL_ONE;
      2'b01:   count_nxt = count_q - FILL_ONE;
      default: count_nxt = count_q;
    endcase
  end

  // The head register reloads when the head moves or the first word arrives.
  // If that word is being written this very cycle the RAM cannot return it
  // yet, so it is captured into the bypass register instead.
  assign load_head = (count_nxt != '0) && (pop || (count_q == '0));
  assign collide   = push && (wr_ptr_q == rd_ptr_nxt);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      blk_cnt_q  <= '0;
      drop_q     <= '0;
      underrun_q <= 1'b0;
      sel_byp_q  <= 1'b1;
      byp_q      <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;

      if (blk_load)     blk_cnt_q <= BLK_LAST;
      else if (blk_dec) blk_cnt_q <= blk_cnt_q - BLK_ONE;

      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (underrun_set)                 underrun_q <= 1'b1;

      if (load_head) begin
        sel_byp_q <= collide;
        if (collide) byp_q <= push_data;
      end
    end
  end

  spike_fifo_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (16)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (push_data),
    .rd_en   (load_head),
    .rd_addr (rd_ptr_nxt),
    .rd_data (ram_q)
  );

  assign ep_datain  = sel_byp_q ? byp_q : ram_q;
  assign ep_ready   = ready_c;
  assign fill_count = count_q;
  assign drop_cnt   = drop_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_spike_pipe_out_fifo.sv
// Scoreboard bench for spike_pipe_out_fifo: a queue models FIFO contents and a
// negedge monitor checks every accepted host read against it.
module tb_spike_pipe_out_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spike_valid;
  logic [15:0] spike_id;
  logic        frame_tick;
  logic        ep_read;
  logic [15:0] ep_datain;
  logic        ep_ready;
  logic [10:0] fill_count;
  logic [15:0] drop_cnt;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] model_q [$];

  spike_pipe_out_fifo #(
    .DEPTH_LOG2  (10),
    .BLOCK_WORDS (256)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .frame_tick  (frame_tick),
    .ep_read     (ep_read),
    .ep_datain   (ep_datain),
    .ep_ready    (ep_ready),
    .fill_count  (fill_count),
    .drop_cnt    (drop_cnt),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a read seen with ep_ready high pops the current head at the next edge.
  always @(negedge clk) begin
    if (reset_n && ep_read && ep_ready) begin
      if (model_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL read_unexpected: got %0h expected no word (t=%0t)", ep_datain, $time);
      end else begin
        check("read_data", ep_datain, model_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic v, input logic [15:0] id, input logic tick, input logic rd);
    spike_valid = v;
    spike_id    = id;
    frame_tick  = tick;
    ep_read     = rd;
    @(posedge clk);
    #1;
    spike_valid = 1'b0;
    frame_tick  = 1'b0;
    ep_read     = 1'b0;
  endtask

  task automatic push(input logic [15:0] id);
    model_q.push_back(id);
    cyc(1'b1, id, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ep_ready"},   32'(ep_ready),   32'h0);
    check({tag, "_ep_datain"},  32'(ep_datain),  32'h0);
    check({tag, "_fill_count"}, 32'(fill_count), 32'h0);
    check({tag, "_drop_cnt"},   32'(drop_cnt),   32'h0);
    check({tag, "_underrun"},   32'(underrun),   32'h0);
  endtask

  initial begin
    reset_n     = 1'b0;
    spike_valid = 1'b0;
    spike_id    = 16'h0;
    frame_tick  = 1'b0;
    ep_read     = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    check_reset_outputs("reset");

    // Block threshold: 255 words not enough, the 256th makes a block.
    for (int i = 0; i < 255; i++) push(16'(i));
    check("thr_ready_255", 32'(ep_ready), 32'h0);
    check("thr_fill_255", 32'(fill_count), 32'd255);
    push(16'd255);
    check("thr_ready_256", 32'(ep_ready), 32'h1);
    for (int i = 0; i < 256; i++) rd();
    check("thr_fill_end", 32'(fill_count), 32'd0);
    check("thr_ready_end", 32'(ep_ready), 32'h0);

    // Underrun: read with 10 words and no block available.
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    check("und_head", 32'(ep_datain), 32'h0100);
    rd();
    check("und_fill", 32'(fill_count), 32'd10);
    check("und_head_held", 32'(ep_datain), 32'h0100);
    check("und_flag", 32'(underrun), 32'h1);

    // Full FIFO: drops, then a simultaneous push and pop at full.
    for (int i = 0; i < 1014; i++) push(16'h0200 + 16'(i));
    check("full_fill", 32'(fill_count), 32'd1024);
    check("full_drop0", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'hDEA0 + 16'(i), 1'b0, 1'b0);
    check("full_drop3", 32'(drop_cnt), 32'd3);
    check("full_fill_after_drop", 32'(fill_count), 32'd1024);
    model_q.push_back(16'h0ABC);
    cyc(1'b1, 16'h0ABC, 1'b0, 1'b1);
    check("full_pushpop_fill", 32'(fill_count), 32'd1024);
    check("full_pushpop_drop", 32'(drop_cnt), 32'd3);
    for (int i = 0; i < 1023; i++) rd();
    check("drain_fill", 32'(fill_count), 32'(model_q.size()));
    check("drain_ready", 32'(ep_ready), 32'h0);
    check("und_sticky", 32'(underrun), 32'h1);

    // Reset in the middle of a block, then a fresh block.
    for (int i = 0; i < 256; i++) push(16'h0300 + 16'(i));
    for (int i = 0; i < 100; i++) rd();
    reset_n = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    model_q.delete();
    check_reset_outputs("midrst");
    for (int i = 0; i < 256; i++) push(16'h0400 + 16'(i));
    check("fresh_ready", 32'(ep_ready), 32'h1);
    check("fresh_head", 32'(ep_datain), 32'h0400);
    for (int i = 0; i < 256; i++) rd();
    check("fresh_fill_end", 32'(fill_count), 32'd0);

    // Frame ticks: markers when compiled in, ignored otherwise.
    model_q.push_back(16'd7);
    cyc(1'b1, 16'd7, 1'b1, 1'b0);
    check("tick_head7", 32'(ep_datain), 32'h7);
`ifdef SPIKE_PIPE_MARKER_EN
    model_q.push_back(16'hFFFF);
`endif
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    model_q.push_back(16'd8);
    cyc(1'b1, 16'd8, 1'b1, 1'b0);
    model_q.push_back(16'd9);
    cyc(1'b1, 16'd9, 1'b1, 1'b0);
`ifdef SPIKE_PIPE_MARKER_EN
    model_q.push_back(16'hFFFF);
`endif
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("tick_fill", 32'(fill_count), 32'(model_q.size()));
    while (model_q.size() < 256) push(16'h0500 + 16'(model_q.size()));
    check("tick_ready", 32'(ep_ready), 32'h1);
    for (int i = 0; i < 256; i++) rd();
    check("tick_fill_end", 32'(fill_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
